// File: rtl/sgb_packet_tx_if.sv
// ---------------------------------------------------------------------------
// sgb_packet_tx_if
// Bus bundle for the SGB packet transmitter.
//   wr / wr_addr / wr_data : packet buffer byte write (master -> slave)
//   start / abort          : transmission control (master -> slave)
//   busy / done            : transmission status (slave -> master)
//   p54_out                : {P15,P14} joypad select line drive (slave -> master)
// ---------------------------------------------------------------------------
interface sgb_packet_tx_if;
    logic       wr;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic [1:0] p54_out;

    modport master (
        output wr, wr_addr, wr_data, start, abort,
        input  busy, done, p54_out
    );

    modport slave (
        input  wr, wr_addr, wr_data, start, abort,
        output busy, done, p54_out
    );
endinterface

// File: rtl/sgb_packet_tx.sv
// ---------------------------------------------------------------------------
// sgb_packet_tx
// Serialises one 16-byte SGB command packet onto the Game Boy joypad select
// lines. The output feeds the joy_p54 input of the ICD2 packet decoder.
// Line sequence: reset pulse (both low), high, 128 data bits (byte 0 first,
// LSB first, '1' = P15 low, '0' = P14 low) each followed by a high phase,
// then a '0' stop bit and a final high phase.
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high reset
//   ce     : GB clock enable; every line phase is timed in ce ticks
//   bus    : sgb_packet_tx_if.slave (write port, start/abort, busy/done,
//            p54_out = {P15,P14}, idle 2'b11)
// ---------------------------------------------------------------------------
module sgb_packet_tx #(
    parameter int RST_TICKS  = 4,
    parameter int LOW_TICKS  = 4,
    parameter int HIGH_TICKS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    sgb_packet_tx_if.slave    bus
);

    localparam int TMAX_A = (RST_TICKS > LOW_TICKS) ? RST_TICKS : LOW_TICKS;
    localparam int TMAX   = (TMAX_A > HIGH_TICKS) ? TMAX_A : HIGH_TICKS;
    localparam int TW     = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

    localparam logic [TW-1:0] T_RST  = TW'(RST_TICKS);
    localparam logic [TW-1:0] T_LOW  = TW'(LOW_TICKS);
    localparam logic [TW-1:0] T_HIGH = TW'(HIGH_TICKS);
    localparam logic [TW-1:0] T_ONE  = TW'(1);

    localparam logic [1:0] P_BOTH_LO = 2'b00;
    localparam logic [1:0] P_IDLE    = 2'b11;
    localparam logic [1:0] P_ONE     = 2'b01;   // P15 low
    localparam logic [1:0] P_ZERO    = 2'b10;   // P14 low

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_LO,
        S_RST_HI,
        S_BIT_LO,
        S_BIT_HI,
        S_STOP_LO,
        S_STOP_HI,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [1:0]    r_p54;
    logic          r_busy;
    logic          r_done;
    logic [6:0]    r_bitcnt;
    logic [TW-1:0] r_tick;
    logic [7:0]    r_buf [16];

    logic [6:0]    w_sel_idx;
    logic [7:0]    w_sel_byte;
    logic          w_sel_bit;
    logic [1:0]    w_bit_pat;

    assign bus.p54_out = r_p54;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;

    // Packet buffer. Writes are locked out for the whole transmission,
    // including the DONE cycle, so the packet on the wire is stable.
    always_ff @(posedge clk) begin
        if (bus.wr && !r_busy) begin
            r_buf[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Bit about to be driven: from BIT_HI the next bit is bitcnt+1, from
    // RST_HI it is bit 0 (bitcnt is cleared on start).
    assign w_sel_idx  = (r_state == S_BIT_HI) ? (r_bitcnt + 7'd1) : r_bitcnt;
    assign w_sel_byte = r_buf[w_sel_idx[6:3]];
    assign w_sel_bit  = w_sel_byte[w_sel_idx[2:0]];
    assign w_bit_pat  = w_sel_bit ? P_ONE : P_ZERO;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_p54    <= P_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_bitcnt <= 7'd0;
            r_tick   <= '0;
        end else begin
            r_done <= 1'b0;
            if (bus.abort && (r_state != S_IDLE)) begin
                r_state  <= S_IDLE;
                r_p54    <= P_IDLE;
                r_busy   <= 1'b0;
                r_bitcnt <= 7'd0;
                r_tick   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // Start is taken immediately, independent of ce.
                        if (bus.start) begin
                            r_state  <= S_RST_LO;
                            r_p54    <= P_BOTH_LO;
                            r_busy   <= 1'b1;
                            r_bitcnt <= 7'd0;
                            r_tick   <= T_RST;
                        end
                    end

                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end

                    default: begin
                        if (ce) begin
                            if (r_tick != T_ONE) begin
                                r_tick <= r_tick - T_ONE;
                            end else begin
                                case (r_state)
                                    S_RST_LO: begin
                                        r_state <= S_RST_HI;
                                        r_p54   <= P_IDLE;
                                        r_tick  <= T_HIGH;
                                    end
                                    S_RST_HI: begin
                                        r_state <= S_BIT_LO;
                                        r_p54   <= w_bit_pat;
                                        r_tick  <= T_LOW;
                                    end
                                    S_BIT_LO: begin
                                        r_state <= S_BIT_HI;
                                        r_p54   <= P_IDLE;
                                        r_tick  <= T_HIGH;
                                    end
                                    S_BIT_HI: begin
                                        if (r_bitcnt == 7'd127) begin
                                            r_state <= S_STOP_LO;
                                            r_p54   <= P_ZERO;
                                        end else begin
                                            r_state  <= S_BIT_LO;
                                            r_p54    <= w_bit_pat;
                                            r_bitcnt <= r_bitcnt + 7'd1;
                                        end
                                        r_tick <= T_LOW;
                                    end
                                    S_STOP_LO: begin
                                        r_state <= S_STOP_HI;
                                        r_p54   <= P_IDLE;
                                        r_tick  <= T_HIGH;
                                    end
                                    S_STOP_HI: begin
                                        r_state <= S_DONE;
                                        r_done  <= 1'b1;
                                        r_tick  <= '0;
                                    end
                                    default: begin
                                        r_state <= S_IDLE;
                                        r_p54   <= P_IDLE;
                                        r_busy  <= 1'b0;
                                    end
                                endcase
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sgb_packet_tx.sv
// ---------------------------------------------------------------------------
// tb_sgb_packet_tx
// Directed sequence with randomized buffer contents and ce patterns. The
// expected line waveform is built per ce tick from the packet bytes; the
// observed waveform is also decoded back into bytes as the ICD2 would.
// ---------------------------------------------------------------------------
module tb_sgb_packet_tx;

    localparam int RT = 4;
    localparam int LT = 4;
    localparam int HT = 4;
    localparam int TOTAL = RT + HT + 129 * (LT + HT);

    logic clk;
    logic reset;
    logic ce;

    sgb_packet_tx_if bus ();

    sgb_packet_tx #(
        .RST_TICKS (RT),
        .LOW_TICKS (LT),
        .HIGH_TICKS(HT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .ce   (ce),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] mdl_buf [16];
    logic [1:0] exp_seq [$];
    bit         rx_bits [$];

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [3:0] a, input logic [7:0] d);
        bus.wr      = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        mdl_buf[a]  = d;
        step();
        bus.wr = 1'b0;
    endtask

    // Expected line value for each ce tick of a full packet.
    task automatic build_seq();
        logic [7:0] byt;
        exp_seq.delete();
        for (int k = 0; k < RT; k++) exp_seq.push_back(2'b00);
        for (int k = 0; k < HT; k++) exp_seq.push_back(2'b11);
        for (int b = 0; b < 129; b++) begin
            logic [1:0] lo;
            if (b == 128) lo = 2'b10;
            else begin
                byt = mdl_buf[b / 8];
                lo  = byt[b % 8] ? 2'b01 : 2'b10;
            end
            for (int k = 0; k < LT; k++) exp_seq.push_back(lo);
            for (int k = 0; k < HT; k++) exp_seq.push_back(2'b11);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_p54"},  {6'd0, bus.p54_out}, 8'h03);
        chk({tag, "_busy"}, {7'd0, bus.busy},    8'h00);
        chk({tag, "_done"}, {7'd0, bus.done},    8'h00);
    endtask

    // ce_div: 0 = random ce, N = ce every Nth clk.
    // abort_at / reset_at: ce index at which to interrupt (-1 = never).
    task automatic send_packet(input string tag, input int ce_div, input int abort_at,
                               input int reset_at, input bit poke,
                               input bit sw_en, input logic [3:0] sw_addr,
                               input logic [7:0] sw_data, input bit decode);
        int         n;
        int         cyc;
        logic [1:0] prev;
        logic [1:0] cur;
        logic [7:0] rb;
        if (sw_en) begin
            bus.wr      = 1'b1;
            bus.wr_addr = sw_addr;
            bus.wr_data = sw_data;
            mdl_buf[sw_addr] = sw_data;
        end
        build_seq();
        bus.start = 1'b1;
        ce = 1'($urandom_range(0, 1));
        step();
        bus.start = 1'b0;
        bus.wr    = 1'b0;
        chk({tag, "_start_busy"}, {7'd0, bus.busy},    8'h01);
        chk({tag, "_start_p54"},  {6'd0, bus.p54_out}, {6'd0, exp_seq[0]});
        chk({tag, "_start_done"}, {7'd0, bus.done},    8'h00);
        n = 0;
        cyc = 0;
        prev = 2'b00;
        rx_bits.delete();
        while (n < TOTAL) begin
            cyc++;
            if (cyc > 20000) begin
                n_checks++;
                n_fail++;
                $error("FAIL %s_timeout got=%0d exp=%0d", tag, n, TOTAL);
                return;
            end
            if (ce_div == 0) ce = 1'($urandom_range(0, 1));
            else             ce = ((cyc % ce_div) == 0);
            if (n == abort_at) begin
                bus.abort = 1'b1;
                step();
                bus.abort = 1'b0;
                chk_idle({tag, "_abort"});
                for (int k = 0; k < 20; k++) begin
                    ce = 1'($urandom_range(0, 1));
                    step();
                    chk_idle({tag, "_post_abort"});
                end
                $display("%s: aborted at ce %0d", tag, n);
                return;
            end
            if (n == reset_at) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                chk_idle({tag, "_reset"});
                ce = 1'b0;
                for (int k = 0; k < 100; k++) begin
                    step();
                    chk_idle({tag, "_frozen"});
                end
                $display("%s: reset at ce %0d", tag, n);
                return;
            end
            if (poke && cyc == 50) begin
                bus.wr      = 1'b1;
                bus.wr_addr = 4'd3;
                bus.wr_data = 8'hAA;
                bus.start   = 1'b1;
            end
            step();
            bus.wr    = 1'b0;
            bus.start = 1'b0;
            if (ce) n++;
            if (n < TOTAL) begin
                chk({tag, "_p54"},  {6'd0, bus.p54_out}, {6'd0, exp_seq[n]});
                chk({tag, "_busy"}, {7'd0, bus.busy},    8'h01);
                chk({tag, "_done"}, {7'd0, bus.done},    8'h00);
                cur = bus.p54_out;
                if (cur != prev && (cur == 2'b01 || cur == 2'b10)) rx_bits.push_back(cur == 2'b01);
                prev = cur;
            end
        end
        chk({tag, "_done_pulse"}, {7'd0, bus.done},    8'h01);
        chk({tag, "_done_busy"},  {7'd0, bus.busy},    8'h01);
        chk({tag, "_done_p54"},   {6'd0, bus.p54_out}, 8'h03);
        ce = 1'($urandom_range(0, 1));
        step();
        chk_idle({tag, "_end"});
        if (decode) begin
            chk({tag, "_nbits"}, 8'(rx_bits.size()), 8'd129);
            if (rx_bits.size() == 129) begin
                for (int i = 0; i < 16; i++) begin
                    for (int j = 0; j < 8; j++) rb[j] = rx_bits[i * 8 + j];
                    chk({tag, "_rxbyte"}, rb, mdl_buf[i]);
                end
                chk({tag, "_stopbit"}, {7'd0, rx_bits[128]}, 8'h00);
            end
        end
        $display("%s: packet complete after %0d clk", tag, cyc);
    endtask

    initial begin
        logic [7:0] rb;
        reset       = 1'b1;
        ce          = 1'b0;
        bus.wr      = 1'b0;
        bus.wr_addr = 4'd0;
        bus.wr_data = 8'd0;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk_idle("reset");
        $display("reset: p54=%b busy=%b done=%b", bus.p54_out, bus.busy, bus.done);

        // 0x01 then fifteen zeros, ce every 3rd clk.
        wr_byte(4'd0, 8'h01);
        for (int i = 1; i < 16; i++) wr_byte(4'(i), 8'h00);
        send_packet("t2_0x01", 3, -1, -1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1);

        // MLT_REQ packet, random ce; decoded header bytes as the ICD2 sees them.
        wr_byte(4'd0, 8'h89);
        wr_byte(4'd1, 8'h01);
        send_packet("t3_mlt", 0, -1, -1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1);
        if (rx_bits.size() == 129) begin
            for (int j = 0; j < 8; j++) rb[j] = rx_bits[j];
            chk("t3_icd2_7000", rb, 8'h89);
            for (int j = 0; j < 8; j++) rb[j] = rx_bits[8 + j];
            chk("t3_icd2_7001", rb, 8'h01);
        end

        // Random packet, abort at ce 500, then a full packet.
        for (int i = 0; i < 16; i++) wr_byte(4'(i), 8'($urandom));
        send_packet("t4_abort", 0, 500, -1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
        send_packet("t4_after", 0, -1, -1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1);

        // Write and start while busy are both ignored.
        wr_byte(4'd3, 8'h55);
        send_packet("t5_poke", 2, -1, -1, 1'b1, 1'b0, 4'd0, 8'd0, 1'b1);
        send_packet("t5_check", 0, -1, -1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1);

        // Reset in the low phase of data bit 10, then a frozen idle.
        send_packet("t6_reset", 0, -1, RT + HT + 10 * (LT + HT) + 2, 1'b0,
                    1'b0, 4'd0, 8'd0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            ce = 1'($urandom_range(0, 1));
            step();
            chk_idle("t6_no_restart");
        end

        // start and wr in the same IDLE cycle: the new byte is transmitted.
        send_packet("t7_sw", 0, -1, -1, 1'b0, 1'b1, 4'd0, 8'($urandom) ^ mdl_buf[0] | 8'h80,
                    1'b1);

        // abort in IDLE is harmless.
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk_idle("idle_abort");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
